// File: rtl/vfs_pkg.sv
// vector_frame_streamer shared types and helpers.
// Default geometry matches the two-channel X/Y display.
package vfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DATA_WIDTH_DEF = 9;
    localparam int N_CH_DEF       = 2;
    localparam int SAMPLE_W       = N_CH_DEF * DATA_WIDTH_DEF;
    localparam int MAX_W          = 64;

    // Extract channel ch (dw bits wide) from a packed sample word.
    function automatic logic [31:0] chan(
        input logic [MAX_W-1:0] word,
        input int               ch,
        input int               dw
    );
        logic [MAX_W-1:0] sh;
        logic [MAX_W-1:0] mask;
        sh   = word >> (ch * dw);
        mask = (MAX_W'(1) << dw) - MAX_W'(1);
        return 32'(sh & mask);
    endfunction

endpackage

// File: rtl/image_ROM.sv
// Packed sample ROM with a synchronous, enabled read port.
// The output register holds its value between reads.
module image_ROM #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 2387,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter     FILE       = "image.mem"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= mem[addr];
    end
  end

endmodule

// File: rtl/vector_frame_streamer.sv
// Plays an address window of a packed sample ROM to the vector DACs,
// paced by a rate divider, in loop or one-shot mode.
module vector_frame_streamer
    import vfs_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int N_CH       = 2,
    parameter int DEPTH      = 2387,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RATE_W     = 16,
    parameter     FILE       = "image.mem"
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic                         i_oneshot,
    input  logic                         i_hold,
    input  logic [ADDR_W-1:0]            i_start_addr,
    input  logic [ADDR_W-1:0]            i_end_addr,
    input  logic [RATE_W-1:0]            i_rate_div,
    output logic [N_CH*DATA_WIDTH-1:0]   o_dac,
    output logic                         o_valid,
    output logic                         o_blank,
    output logic                         o_frame_done,
    output logic                         o_busy,
    output logic [ADDR_W-1:0]            o_addr
);

    localparam int SW = N_CH * DATA_WIDTH;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [RATE_W-1:0] rate_cnt;
    logic [ADDR_W-1:0] win_s;
    logic [ADDR_W-1:0] win_e;
    logic              oneshot_r;
    logic [ADDR_W-1:0] s_in;
    logic [ADDR_W-1:0] e_clamp;
    logic [ADDR_W-1:0] e_in;
    logic              tick;
    logic              issue;

    // Keep both window ends inside the ROM; a reversed window collapses to s.
    always_comb begin
        s_in    = (i_start_addr > LAST) ? LAST : i_start_addr;
        e_clamp = (i_end_addr > LAST) ? LAST : i_end_addr;
        e_in    = (s_in > e_clamp) ? s_in : e_clamp;
    end

    assign tick   = (state == RUN) && (rate_cnt == i_rate_div) && !i_hold;
    assign issue  = tick && i_enable;
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            rate_cnt     <= '0;
            o_addr       <= '0;
            win_s        <= '0;
            win_e        <= '0;
            oneshot_r    <= 1'b0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_blank      <= 1'b1;
        end else begin
            o_valid      <= issue;
            o_frame_done <= issue && (o_addr == win_e);

            if (!i_enable) begin
                o_blank <= 1'b1;
            end else if (state == RUN && i_hold) begin
                o_blank <= 1'b1;
            end else if (tick) begin
                o_blank <= 1'b0;
            end else if (state == IDLE) begin
                o_blank <= 1'b1;
            end

            if (!i_enable) begin
                state    <= IDLE;
                rate_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state     <= RUN;
                        rate_cnt  <= '0;
                        o_addr    <= s_in;
                        win_s     <= s_in;
                        win_e     <= e_in;
                        oneshot_r <= i_oneshot;
                    end
                    RUN: begin
                        if (!i_hold && !tick) begin
                            rate_cnt <= rate_cnt + 1'b1;
                        end else if (tick) begin
                            rate_cnt <= '0;
                            if (o_addr != win_e) begin
                                o_addr <= o_addr + 1'b1;
                            end else if (!oneshot_r) begin
                                o_addr    <= s_in;
                                win_s     <= s_in;
                                win_e     <= e_in;
                                oneshot_r <= i_oneshot;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    image_ROM #(
        .DATA_WIDTH (SW),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .FILE       (FILE)
    ) u_rom (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (issue),
        .addr  (o_addr),
        .data  (o_dac)
    );

endmodule

// File: tb/tb_vector_frame_streamer.sv
// Randomised self-checking bench for vector_frame_streamer.
// Expected streams come from window arithmetic on a ROM image.
module tb_vector_frame_streamer;
    import vfs_pkg::*;

    localparam int DW    = DATA_WIDTH_DEF;
    localparam int NC    = N_CH_DEF;
    localparam int SW    = SAMPLE_W;
    localparam int DEPTH = 2387;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = 16;
    localparam int NMAX  = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          oneshot = 1'b0;
    logic          hold = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [RW-1:0] rate_div = '0;
    logic [SW-1:0] dac;
    logic          valid;
    logic          blank;
    logic          frame_done;
    logic          busy;
    logic [AW-1:0] addr;

    logic [SW-1:0] rom [DEPTH];
    int checks = 0;
    int fails = 0;

    logic          ov [NMAX];
    logic          ofd [NMAX];
    logic          obl [NMAX];
    logic          obusy [NMAX];
    logic [SW-1:0] odac [NMAX];
    logic [AW-1:0] oaddr [NMAX];

    always #5 clk = ~clk;

    vector_frame_streamer #(
        .DATA_WIDTH (DW),
        .N_CH       (NC),
        .DEPTH      (DEPTH),
        .RATE_W     (RW),
        .FILE       ("")
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_oneshot    (oneshot),
        .i_hold       (hold),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .i_rate_div   (rate_div),
        .o_dac        (dac),
        .o_valid      (valid),
        .o_blank      (blank),
        .o_frame_done (frame_done),
        .o_busy       (busy),
        .o_addr       (addr)
    );

    // Sample t (t=1 is the edge entering RUN): window s..e' played from s,
    // one sample every rd+1 cycles, first visible at t = rd+2.
    function automatic void model(
        input  int s,
        input  int e,
        input  int rd,
        input  bit os,
        input  int t,
        output bit v,
        output int a,
        output bit fd
    );
        int ee;
        int len;
        int k;
        ee = (e > DEPTH - 1) ? DEPTH - 1 : e;
        if (s > ee) ee = s;
        len = ee - s + 1;
        v = 0;
        a = s;
        fd = 0;
        if (t >= rd + 2 && (t - 1) % (rd + 1) == 0) begin
            k = (t - 1) / (rd + 1) - 1;
            if (!os || k < len) begin
                v = 1;
                a = s + k % len;
                fd = (k % len == len - 1);
            end
        end
    endfunction

    task automatic start(input int s, input int e, input int rd, input bit os);
        start_addr = AW'(s);
        end_addr   = AW'(e);
        rate_div   = RW'(rd);
        oneshot    = os;
        hold       = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic stop();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            ov[t]    = valid;
            ofd[t]   = frame_done;
            obl[t]   = blank;
            obusy[t] = busy;
            odac[t]  = dac;
            oaddr[t] = addr;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (dac !== '0 || valid !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_data got dac=%h v=%b fd=%b want 0 0 0",
                     dac, valid, frame_done);
        end
        checks++;
        if (blank !== 1'b1 || busy !== 1'b0 || addr !== '0) begin
            fails++;
            $display("FAIL reset_ctl got blank=%b busy=%b addr=%0d want 1 0 0",
                     blank, busy, addr);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loop();
        bit v;
        bit fd;
        int a;
        int s = 0;
        int e = 3;
        start(s, e, 0, 1'b0);
        capture(20);
        for (int t = 1; t <= 20; t++) begin
            model(s, e, 0, 1'b0, t, v, a, fd);
            checks++;
            if (ov[t] !== v || ofd[t] !== fd || obusy[t] !== 1'b1) begin
                fails++;
                $display("FAIL loop_ctl t=%0d got v=%b fd=%b busy=%b want %b %b 1",
                         t, ov[t], ofd[t], obusy[t], v, fd);
            end
            checks++;
            if (obl[t] !== (t < 2)) begin
                fails++;
                $display("FAIL loop_blank t=%0d got %b want %b", t, obl[t], t < 2);
            end
            if (v) begin
                checks++;
                if (odac[t] !== rom[a]) begin
                    fails++;
                    $display("FAIL loop_dac t=%0d got %h want %h", t, odac[t], rom[a]);
                end
                checks++;
                if (chan(MAX_W'(odac[t]), 1, DW) !== chan(MAX_W'(rom[a]), 1, DW)) begin
                    fails++;
                    $display("FAIL loop_ych t=%0d got %h want %h", t,
                             chan(MAX_W'(odac[t]), 1, DW), chan(MAX_W'(rom[a]), 1, DW));
                end
            end
        end
        stop();
    endtask

    task automatic test_oneshot();
        bit v;
        bit fd;
        int a;
        int n = 0;
        start(10, 12, 3, 1'b1);
        capture(30);
        for (int t = 1; t <= 30; t++) begin
            model(10, 12, 3, 1'b1, t, v, a, fd);
            n += int'(ov[t]);
            checks++;
            if (ov[t] !== v || ofd[t] !== fd || obusy[t] !== 1'b1) begin
                fails++;
                $display("FAIL oneshot_ctl t=%0d got v=%b fd=%b busy=%b want %b %b 1",
                         t, ov[t], ofd[t], obusy[t], v, fd);
            end
            if (v) begin
                checks++;
                if (odac[t] !== rom[a]) begin
                    fails++;
                    $display("FAIL oneshot_dac t=%0d got %h want %h", t, odac[t], rom[a]);
                end
            end
        end
        checks++;
        if (n != 3) begin
            fails++;
            $display("FAIL oneshot_count got %0d want 3", n);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || blank !== 1'b1 || valid !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_off got busy=%b blank=%b v=%b want 0 1 0",
                     busy, blank, valid);
        end
        stop();
    endtask

    task automatic test_window(input int s, input int e, input int rd,
                               input bit os, input int n);
        bit v;
        bit fd;
        int a;
        start(s, e, rd, os);
        capture(n);
        for (int t = 1; t <= n; t++) begin
            model(s, e, rd, os, t, v, a, fd);
            checks++;
            if (ov[t] !== v || ofd[t] !== fd) begin
                fails++;
                $display("FAIL window_ctl s=%0d e=%0d rd=%0d t=%0d got v=%b fd=%b want %b %b",
                         s, e, rd, t, ov[t], ofd[t], v, fd);
            end
            checks++;
            if (int'(oaddr[t]) >= DEPTH || int'(oaddr[t]) < s) begin
                fails++;
                $display("FAIL window_addr t=%0d got %0d want %0d..%0d",
                         t, oaddr[t], s, DEPTH - 1);
            end
            if (v) begin
                checks++;
                if (odac[t] !== rom[a]) begin
                    fails++;
                    $display("FAIL window_dac t=%0d got %h want %h", t, odac[t], rom[a]);
                end
            end
        end
        stop();
    endtask

    task automatic test_random();
        int s;
        int len;
        for (int i = 0; i < 4; i++) begin
            s   = int'($urandom_range(DEPTH - 1, 0));
            len = int'($urandom_range(6, 1));
            test_window(s, s + len - 1, int'($urandom_range(3, 0)),
                        1'($urandom % 2), 40);
        end
    endtask

    task automatic test_hold();
        logic [SW-1:0] got [$];
        logic [AW-1:0] frozen = '0;
        start(30, 45, 1, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk);
            #1;
            if (valid) got.push_back(dac);
            if (t >= 11 && t <= 15) begin
                checks++;
                if (valid !== 1'b0 || blank !== 1'b1 || addr !== frozen) begin
                    fails++;
                    $display("FAIL hold t=%0d got v=%b blank=%b addr=%0d want 0 1 %0d",
                             t, valid, blank, addr, frozen);
                end
            end
            if (t == 10) begin
                frozen = addr;
                hold = 1'b1;
            end
            if (t == 15) hold = 1'b0;
        end
        checks++;
        if (got.size() < 10) begin
            fails++;
            $display("FAIL hold_count got %0d want >=10", got.size());
        end
        foreach (got[i]) begin
            checks++;
            if (got[i] !== rom[30 + i % 16]) begin
                fails++;
                $display("FAIL hold_seq i=%0d got %h want %h", i, got[i], rom[30 + i % 16]);
            end
        end
        stop();
    endtask

    task automatic test_disable();
        bit found = 0;
        bit v;
        bit fd;
        int a;
        start(0, 15, 0, 1'b0);
        for (int t = 1; t <= 40 && !found; t++) begin
            @(posedge clk);
            #1;
            if (addr == AW'(7)) found = 1;
        end
        checks++;
        if (!found || valid !== 1'b1 || dac !== rom[6]) begin
            fails++;
            $display("FAIL disable_pre found=%b v=%b dac=%h want 1 1 %h",
                     found, valid, dac, rom[6]);
        end
        enable = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            @(posedge clk);
            #1;
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || blank !== 1'b1) begin
                fails++;
                $display("FAIL disable_post t=%0d got v=%b busy=%b blank=%b want 0 0 1",
                         t, valid, busy, blank);
            end
        end
        start(0, 15, 0, 1'b0);
        capture(6);
        for (int t = 1; t <= 6; t++) begin
            model(0, 15, 0, 1'b0, t, v, a, fd);
            checks++;
            if (ov[t] !== v || (v && odac[t] !== rom[a])) begin
                fails++;
                $display("FAIL disable_restart t=%0d got v=%b dac=%h want %b %h",
                         t, ov[t], odac[t], v, rom[a]);
            end
        end
        stop();
    endtask

    task automatic test_reset_mid();
        start(100, 103, 0, 1'b0);
        capture(6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dac !== '0 || valid !== 1'b0 || blank !== 1'b1 ||
            busy !== 1'b0 || addr !== '0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got dac=%h v=%b bl=%b busy=%b addr=%0d fd=%b want 0 0 1 0 0 0",
                     dac, valid, blank, busy, addr, frame_done);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(100, 103, 0, 1'b0);
        capture(2);
        checks++;
        if (ov[2] !== 1'b1 || odac[2] !== rom[100]) begin
            fails++;
            $display("FAIL reset_rom got v=%b dac=%h want 1 %h", ov[2], odac[2], rom[100]);
        end
        stop();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = SW'(($urandom % 64) << AW) | SW'(i);
            dut.u_rom.mem[i] = rom[i];
        end
        test_reset();
        test_loop();
        test_oneshot();
        test_window(20, 5, 1, 1'b0, 20);
        test_window(2385, 4000, 0, 1'b0, 14);
        test_random();
        test_hold();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_frame_streamer.md
Name: vector_frame_streamer

Overview:
Parametrised successor to the fixed two-channel X/Y ROM streamer that feeds the vector-display DACs. It plays a programmable address window of a packed N_CH-channel sample ROM and paces output with a programmable rate divider. It supports loop and one-shot modes, pause, and beam blanking, and pulses a frame-done strobe. It sits between the control registers and the DAC output pins.

Parameters:
DATA_WIDTH, 9, bits per channel sample
N_CH, 2, channels per sample (X, Y, optional Z/intensity)
DEPTH, 2387, ROM words
ADDR_W, $clog2(DEPTH), address width
RATE_W, 16, rate divider width
FILE, "image.mem", hex init file; each word is N_CH*DATA_WIDTH bits, channel 0 in the LSBs

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  level; 1 = stream, 0 = stop
i_oneshot  in  1  1 = play window once then stop; 0 = loop
i_hold  in  1  pause; freezes address and rate counter
i_start_addr  in  ADDR_W  first window address
i_end_addr  in  ADDR_W  last window address, inclusive
i_rate_div  in  RATE_W  one sample every i_rate_div+1 cycles
o_dac  out  N_CH*DATA_WIDTH  packed channel samples
o_valid  out  1  o_dac holds a freshly issued sample (1-cycle pulse per sample)
o_blank  out  1  1 = beam off; DAC value meaningless
o_frame_done  out  1  1-cycle pulse with the last sample of the window
o_busy  out  1  FSM not IDLE
o_addr  out  ADDR_W  address currently issued to the ROM

Behaviour:
- Reset values: o_dac=0, o_valid=0, o_blank=1, o_frame_done=0, o_busy=0, o_addr=0, FSM=IDLE, rate_cnt=0.
- Window latch: on IDLE->RUN and at every loop wrap, capture s=i_start_addr, e=min(i_end_addr, DEPTH-1) and the mode. If s>e, set e=s, giving a single-sample window. Window and mode changes mid-frame take effect at the next wrap only.
- FSM states:
  - IDLE: i_enable=1 -> RUN; o_addr=s, rate_cnt=0.
  - RUN: tick = (rate_cnt==i_rate_div) && !i_hold. rate_cnt counts up, clears on tick, and holds while i_hold=1. On tick, issue o_addr to the ROM, then:
    - o_addr<e: increment.
    - o_addr==e, loop mode: wrap to s and relatch.
    - o_addr==e, one-shot mode: go to DONE.
  - DONE: wait for the last sample to drain (1 cycle), then hold until i_enable=0 -> IDLE.
  - Any state, i_enable=0 -> IDLE next cycle, including mid-frame. No drain; the in-flight sample is discarded.
- Latency: ROM read is synchronous, 1 cycle. A sample issued on tick at cycle n appears on o_dac with o_valid=1 at cycle n+1. o_frame_done asserts in the same cycle as o_valid for the sample of address e.
- o_dac holds its last value between valid pulses.
- o_blank:
  - 0 from the first valid sample until leaving RUN/DONE.
  - 1 in IDLE and during i_hold.
  - Asserts the cycle after i_enable falls.
- i_rate_div=0: one sample per cycle, so loop mode streams continuously with no wrap bubble. i_rate_div is read live each cycle.
- Simultaneous tick and i_enable falling: disable wins, and no o_valid is issued the following cycle.
- o_busy = (state != IDLE).
- Reset mid-operation: immediate return to reset values. ROM contents are unaffected.

Decomposition:
- Package vfs_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Localparam SAMPLE_W = N_CH*DATA_WIDTH.
  - A channel-slice helper function.
- One sub-module: the existing image_ROM, instantiated once with DATA_WIDTH=SAMPLE_W, DEPTH and FILE.
- Rate divider and FSM stay inline.

Test Plan:
- Reset release, i_enable=1, rate_div=0, s=0, e=3, loop, ROM words 0..3 = A,B,C,D -> o_valid every cycle from cycle 2. o_dac sequence A,B,C,D,A,B…; frame_done pulses with each D.
- rate_div=3, s=10, e=12, oneshot -> exactly 3 valid pulses spaced 4 cycles apart. frame_done with address 12. o_busy falls only after i_enable=0.
- s=20, e=5 (s>e) -> single sample at address 20 repeated each tick; frame_done on every sample.
- e=4000 (>DEPTH-1), s=2385 -> addresses 2385, 2386, then wrap to 2385. No address ≥2387 is ever issued.
- i_hold=1 for 5 cycles mid-frame -> no valid pulses, o_blank=1, o_addr frozen. Release resumes at the next address with no skip or duplicate.
- Drop i_enable at address 7 of 0..15 (also at a tick cycle) -> IDLE next cycle, o_blank=1, no extra o_valid. Re-enable restarts at s=0.
